// File: rtl/snake_pkg.sv
// Shared definitions for the snake body engine.
//   DIR_*      : 2-bit direction encodings; the opposite direction is the bitwise inverse
//   state_t    : engine controller states
//   cell_index : flattens a grid coordinate into a bitmap bit index (row-major)
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CHECK,
    ST_COMMIT,
    ST_DEAD
  } state_t;

  function automatic int cell_index(input int x, input int y, input int cols);
    return y * cols + x;
  endfunction

endpackage

// File: rtl/snake_ring.sv
// Circular buffer holding the snake body coordinates, oldest entry = tail.
// Ports:
//   clk, rst       : clock, synchronous active-high clear (pointers only)
//   push, din      : append din as the newest entry
//   pop            : drop the oldest entry
//   oldest, newest : combinational peeks of the tail and head entries
//   empty          : no entries stored
module snake_ring #(
  parameter int W     = 10,
  parameter int DEPTH = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] oldest,
  output logic [W-1:0] newest,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers. A push into a
  // full ring together with a pop overwrites the entry being dropped.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign oldest = mem[rd_ptr];
  assign newest = mem[wr_ptr - 1'b1];
  assign empty  = (count == '0);

endmodule

// File: rtl/snake_engine.sv
// Snake body engine: keeps the body as a coordinate ring plus an occupancy
// bitmap, and advances it one cell per accepted step.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : restart request, only honoured when dead
//   dir, step_valid      : requested direction and move request
//   step_ready           : a step can be accepted (idle)
//   preyx, preyy         : prey position
//   step_done/score      : one-cycle pulses when a step commits / prey eaten
//   erase_valid/x/y      : one-cycle pulse with the vacated tail cell
//   lose                 : sticky collision flag
//   headx/y, tailx/y     : body end coordinates
//   length               : current body length
//   busy                 : initialising or processing a step
module snake_engine
  import snake_pkg::*;
#(
  parameter int H_W       = 5,
  parameter int V_W       = 5,
  parameter int H_MAX     = 31,
  parameter int V_MAX     = 23,
  parameter int DEPTH     = 128,
  parameter int LEN_W     = 8,
  parameter int INIT_LEN  = 3,
  parameter int START_X   = 16,
  parameter int START_Y   = 11,
  parameter int WRAP_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       dir,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [H_W-1:0]   preyx,
  input  logic [V_W-1:0]   preyy,
  output logic             step_done,
  output logic             score,
  output logic             lose,
  output logic             erase_valid,
  output logic [H_W-1:0]   erasex,
  output logic [V_W-1:0]   erasey,
  output logic [H_W-1:0]   headx,
  output logic [V_W-1:0]   heady,
  output logic [H_W-1:0]   tailx,
  output logic [V_W-1:0]   taily,
  output logic [LEN_W-1:0] length,
  output logic             busy
);

  localparam int COLS  = H_MAX + 1;
  localparam int CELLS = COLS * (V_MAX + 1);
  localparam int IW    = $clog2(CELLS);
  localparam int CW    = H_W + V_W;

  state_t state, state_nxt;

  logic [CELLS-1:0] bitmap;
  logic [1:0]       cur_dir;
  logic [LEN_W-1:0] init_cnt;
  logic [H_W-1:0]   nxt_x;
  logic [V_W-1:0]   nxt_y;
  logic             wall_hit, eat, hit;

  logic [H_W-1:0]   cand_x, init_x;
  logic [V_W-1:0]   cand_y;
  logic             cand_wall, cand_eat, cand_grow, cand_hit;
  logic [IW-1:0]    cand_idx, nxt_idx, tail_idx, init_idx;
  logic             restart, commit_ok, grow;
  logic             ring_push, ring_pop, ring_clear, ring_empty;
  logic [CW-1:0]    ring_din, ring_oldest, ring_newest;

  assign restart   = (state == ST_DEAD) && start;
  assign commit_ok = (state == ST_COMMIT) && !(wall_hit || hit);
  assign grow      = eat && (length < LEN_W'(DEPTH));

  assign init_x     = H_W'(START_X - INIT_LEN + 1 + int'(init_cnt));
  assign ring_clear = rst || restart;
  assign ring_push  = (state == ST_INIT) || commit_ok;
  assign ring_pop   = commit_ok && !grow;
  assign ring_din   = (state == ST_INIT) ? {V_W'(START_Y), init_x} : {nxt_y, nxt_x};

  snake_ring #(.W(CW), .DEPTH(DEPTH)) u_ring (
    .clk    (clk),
    .rst    (ring_clear),
    .push   (ring_push),
    .pop    (ring_pop),
    .din    (ring_din),
    .oldest (ring_oldest),
    .newest (ring_newest),
    .empty  (ring_empty)
  );

  // With an empty ring both ends sit on the start cell.
  assign headx = ring_empty ? H_W'(START_X) : ring_newest[H_W-1:0];
  assign heady = ring_empty ? V_W'(START_Y) : ring_newest[CW-1:H_W];
  assign tailx = ring_empty ? H_W'(START_X) : ring_oldest[H_W-1:0];
  assign taily = ring_empty ? V_W'(START_Y) : ring_oldest[CW-1:H_W];

  assign cand_idx = IW'(cell_index(int'(cand_x), int'(cand_y), COLS));
  assign nxt_idx  = IW'(cell_index(int'(nxt_x), int'(nxt_y), COLS));
  assign tail_idx = IW'(cell_index(int'(tailx), int'(taily), COLS));
  assign init_idx = IW'(cell_index(int'(init_x), START_Y, COLS));

  // Next head candidate. On a wall hit the head is left in place so the
  // bitmap lookup stays in range; the move is discarded anyway.
  always_comb begin
    cand_x    = headx;
    cand_y    = heady;
    cand_wall = 1'b0;
    case (cur_dir)
      DIR_UP: begin
        if (heady == '0) begin
          if (WRAP_MODE != 0) cand_y = V_W'(V_MAX);
          else                cand_wall = 1'b1;
        end else cand_y = heady - 1'b1;
      end
      DIR_DOWN: begin
        if (heady == V_W'(V_MAX)) begin
          if (WRAP_MODE != 0) cand_y = '0;
          else                cand_wall = 1'b1;
        end else cand_y = heady + 1'b1;
      end
      DIR_LEFT: begin
        if (headx == '0) begin
          if (WRAP_MODE != 0) cand_x = H_W'(H_MAX);
          else                cand_wall = 1'b1;
        end else cand_x = headx - 1'b1;
      end
      default: begin
        if (headx == H_W'(H_MAX)) begin
          if (WRAP_MODE != 0) cand_x = '0;
          else                cand_wall = 1'b1;
        end else cand_x = headx + 1'b1;
      end
    endcase
    cand_eat  = (cand_x == preyx) && (cand_y == preyy);
    cand_grow = cand_eat && (length < LEN_W'(DEPTH));
    // The tail cell is about to be vacated unless the snake grows.
    cand_hit  = bitmap[cand_idx] && !cand_wall &&
                !((cand_x == tailx) && (cand_y == taily) && !cand_grow);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    step_ready = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_INIT: begin
        busy = 1'b1;
        if (init_cnt == LEN_W'(INIT_LEN - 1)) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        step_ready = 1'b1;
        if (step_valid) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        busy      = 1'b1;
        state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        busy      = 1'b1;
        state_nxt = (wall_hit || hit) ? ST_DEAD : ST_IDLE;
      end
      ST_DEAD: begin
        if (start) state_nxt = ST_INIT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Body datapath. In COMMIT the old tail bit is cleared before the new head
  // bit is set, so a head moving into the vacated cell keeps its bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap      <= '0;
      cur_dir     <= DIR_RIGHT;
      init_cnt    <= '0;
      length      <= '0;
      lose        <= 1'b0;
      step_done   <= 1'b0;
      score       <= 1'b0;
      erase_valid <= 1'b0;
      erasex      <= '0;
      erasey      <= '0;
      nxt_x       <= '0;
      nxt_y       <= '0;
      wall_hit    <= 1'b0;
      eat         <= 1'b0;
      hit         <= 1'b0;
    end else begin
      step_done   <= 1'b0;
      score       <= 1'b0;
      erase_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          bitmap[init_idx] <= 1'b1;
          length           <= length + 1'b1;
          init_cnt         <= init_cnt + 1'b1;
        end
        ST_IDLE: begin
          if (step_valid && (dir != ~cur_dir)) cur_dir <= dir;
        end
        ST_CHECK: begin
          nxt_x    <= cand_x;
          nxt_y    <= cand_y;
          wall_hit <= cand_wall;
          eat      <= cand_eat;
          hit      <= cand_hit;
        end
        ST_COMMIT: begin
          step_done <= 1'b1;
          if (wall_hit || hit) begin
            lose <= 1'b1;
          end else begin
            score <= eat;
            if (grow) begin
              length <= length + 1'b1;
            end else begin
              erase_valid      <= 1'b1;
              erasex           <= tailx;
              erasey           <= taily;
              bitmap[tail_idx] <= 1'b0;
            end
            bitmap[nxt_idx] <= 1'b1;
          end
        end
        ST_DEAD: begin
          if (start) begin
            bitmap   <= '0;
            length   <= '0;
            lose     <= 1'b0;
            cur_dir  <= DIR_RIGHT;
            init_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Testbench for snake_engine. Three instances share the inputs:
//   0: default (wrap mode, DEPTH 128), 1: wall mode, 2: DEPTH 4.
module tb_snake_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] dir = 2'b01;
  logic       step_valid = 1'b0;
  logic [4:0] preyx = '0;
  logic [4:0] preyy = '0;

  logic       step_ready [3];
  logic       step_done [3];
  logic       score [3];
  logic       lose [3];
  logic       erase_valid [3];
  logic [4:0] erasex [3];
  logic [4:0] erasey [3];
  logic [4:0] headx [3];
  logic [4:0] heady [3];
  logic [4:0] tailx [3];
  logic [4:0] taily [3];
  logic [7:0] length [3];
  logic       busy [3];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    snake_engine #(
      .WRAP_MODE((g == 1) ? 0 : 1),
      .DEPTH    ((g == 2) ? 4 : 128)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dir        (dir),
      .step_valid (step_valid),
      .step_ready (step_ready[g]),
      .preyx      (preyx),
      .preyy      (preyy),
      .step_done  (step_done[g]),
      .score      (score[g]),
      .lose       (lose[g]),
      .erase_valid(erase_valid[g]),
      .erasex     (erasex[g]),
      .erasey     (erasey[g]),
      .headx      (headx[g]),
      .heady      (heady[g]),
      .tailx      (tailx[g]),
      .taily      (taily[g]),
      .length     (length[g]),
      .busy       (busy[g])
    );
  end

  // Resets every instance and waits for INIT to finish; returns at a negedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; step_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  // Issues one step from a negedge; returns at the negedge after commit.
  // early_done reports any step_done seen on instance 0 before that point.
  task automatic do_step(input int d, input int px, input int py, output logic early_done);
    int waitc;
    waitc = 0;
    early_done = 1'b0;
    while (step_ready[0] !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (step_ready[0] !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL step_wait: step_ready=%b required 1", step_ready[0]);
    end
    dir = 2'(d); preyx = 5'(px); preyy = 5'(py); step_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    step_valid = 1'b0;
    early_done = early_done | step_done[0];
    @(posedge clk); @(negedge clk);
    early_done = early_done | step_done[0];
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    tests_run++; if (step_ready[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_ready: got %b want 0", step_ready[0]); end
    tests_run++; if (length[0] !== 8'd0) begin tests_failed++; $display("[TB] FAIL rst_length: got %0d want 0", length[0]); end
    tests_run++; if (lose[0] !== 1'b0 || step_done[0] !== 1'b0 || score[0] !== 1'b0 || erase_valid[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_flags: lose=%b done=%b score=%b erase=%b want 0", lose[0], step_done[0], score[0], erase_valid[0]); end
    tests_run++; if (headx[0] !== 5'd16 || tailx[0] !== 5'd16 || heady[0] !== 5'd11) begin tests_failed++; $display("[TB] FAIL rst_pos: head=(%0d,%0d) tail x=%0d want (16,11) 16", headx[0], heady[0], tailx[0]); end
    tests_run++; if (busy[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_busy: got %b want 1", busy[0]); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (headx[0] !== 5'd16 || heady[0] !== 5'd11) begin tests_failed++; $display("[TB] FAIL init_head: got (%0d,%0d) want (16,11)", headx[0], heady[0]); end
    tests_run++; if (tailx[0] !== 5'd14 || taily[0] !== 5'd11) begin tests_failed++; $display("[TB] FAIL init_tail: got (%0d,%0d) want (14,11)", tailx[0], taily[0]); end
    tests_run++; if (length[0] !== 8'd3) begin tests_failed++; $display("[TB] FAIL init_length: got %0d want 3", length[0]); end
    tests_run++; if (step_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL init_ready: ready=%b busy=%b want 1 0", step_ready[0], busy[0]); end
  endtask

  task automatic test_eat();
    logic early;
    do_reset();
    do_step(1, 17, 11, early);
    tests_run++; if (early !== 1'b0 || step_done[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL eat_latency: early=%b done=%b want 0 1", early, step_done[0]); end
    tests_run++; if (score[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL eat_score: got %b want 1", score[0]); end
    tests_run++; if (headx[0] !== 5'd17 || heady[0] !== 5'd11) begin tests_failed++; $display("[TB] FAIL eat_head: got (%0d,%0d) want (17,11)", headx[0], heady[0]); end
    tests_run++; if (length[0] !== 8'd4) begin tests_failed++; $display("[TB] FAIL eat_length: got %0d want 4", length[0]); end
    tests_run++; if (tailx[0] !== 5'd14 || erase_valid[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL eat_tail: tailx=%0d erase=%b want 14 0", tailx[0], erase_valid[0]); end
    tests_run++; if (step_ready[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL eat_ready: got %b want 1", step_ready[0]); end
    @(negedge clk);
    tests_run++; if (step_done[0] !== 1'b0 || score[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL eat_pulse: done=%b score=%b want 0 0", step_done[0], score[0]); end
  endtask

  task automatic test_wrap();
    logic early;
    do_reset();
    for (int i = 0; i < 15; i++) do_step(1, 0, 0, early);
    tests_run++; if (headx[0] !== 5'd31 || lose[1] !== 1'b0) begin tests_failed++; $display("[TB] FAIL edge_reach: headx=%0d lose1=%b want 31 0", headx[0], lose[1]); end
    do_step(1, 0, 0, early);
    tests_run++; if (headx[0] !== 5'd0 || heady[0] !== 5'd11 || lose[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_head: head=(%0d,%0d) lose=%b want (0,11) 0", headx[0], heady[0], lose[0]); end
    tests_run++; if (lose[1] !== 1'b1 || step_ready[1] !== 1'b0 || step_done[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL wall_lose: lose=%b ready=%b done=%b want 1 0 1", lose[1], step_ready[1], step_done[1]); end
    repeat (3) @(negedge clk);
    tests_run++; if (headx[1] !== 5'd31 || length[1] !== 8'd3 || lose[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL dead_frozen: headx=%0d len=%0d lose=%b want 31 3 1", headx[1], length[1], lose[1]); end
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    tests_run++; if (lose[1] !== 1'b0 || busy[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart: lose=%b busy=%b want 0 1", lose[1], busy[1]); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (headx[1] !== 5'd16 || length[1] !== 8'd3 || step_ready[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_init: headx=%0d len=%0d ready=%b want 16 3 1", headx[1], length[1], step_ready[1]); end
  endtask

  task automatic test_reversal();
    logic early;
    do_reset();
    do_step(2, 0, 0, early);
    tests_run++; if (headx[0] !== 5'd17 || heady[0] !== 5'd11) begin tests_failed++; $display("[TB] FAIL reverse1: got (%0d,%0d) want (17,11)", headx[0], heady[0]); end
    do_step(2, 0, 0, early);
    tests_run++; if (headx[0] !== 5'd18 || lose[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reverse2: headx=%0d lose=%b want 18 0", headx[0], lose[0]); end
    do_step(3, 0, 0, early);
    tests_run++; if (headx[0] !== 5'd18 || heady[0] !== 5'd12) begin tests_failed++; $display("[TB] FAIL turn_down: got (%0d,%0d) want (18,12)", headx[0], heady[0]); end
  endtask

  task automatic test_self_collision();
    logic early;
    do_reset();
    do_step(1, 17, 11, early);
    do_step(1, 18, 11, early);
    tests_run++; if (length[0] !== 8'd5) begin tests_failed++; $display("[TB] FAIL len5: got %0d want 5", length[0]); end
    do_step(0, 0, 0, early);
    do_step(2, 0, 0, early);
    do_step(3, 0, 0, early);
    tests_run++; if (lose[0] !== 1'b1 || step_ready[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL self_hit: lose=%b ready=%b want 1 0", lose[0], step_ready[0]); end
    do_reset();
    do_step(1, 17, 11, early);
    do_step(0, 0, 0, early);
    do_step(2, 0, 0, early);
    do_step(3, 0, 0, early);
    tests_run++; if (lose[0] !== 1'b0 || headx[0] !== 5'd16 || heady[0] !== 5'd11) begin tests_failed++; $display("[TB] FAIL tail_chase: lose=%b head=(%0d,%0d) want 0 (16,11)", lose[0], headx[0], heady[0]); end
    tests_run++; if (erase_valid[0] !== 1'b1 || erasex[0] !== 5'd16 || erasey[0] !== 5'd11) begin tests_failed++; $display("[TB] FAIL tail_chase_erase: v=%b (%0d,%0d) want 1 (16,11)", erase_valid[0], erasex[0], erasey[0]); end
    // The re-entered cell must still count as occupied afterwards.
    do_step(2, 15, 11, early);
    do_step(3, 0, 0, early);
    do_step(1, 0, 0, early);
    do_step(0, 0, 0, early);
    tests_run++; if (lose[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL reentered_cell: lose=%b want 1", lose[0]); end
  endtask

  task automatic test_saturate();
    logic early;
    do_reset();
    do_step(1, 17, 11, early);
    tests_run++; if (length[2] !== 8'd4) begin tests_failed++; $display("[TB] FAIL sat_fill: got %0d want 4", length[2]); end
    do_step(1, 18, 11, early);
    tests_run++; if (score[2] !== 1'b1 || length[2] !== 8'd4) begin tests_failed++; $display("[TB] FAIL sat_score: score=%b len=%0d want 1 4", score[2], length[2]); end
    tests_run++; if (erase_valid[2] !== 1'b1 || erasex[2] !== 5'd14 || erasey[2] !== 5'd11) begin tests_failed++; $display("[TB] FAIL sat_erase: v=%b (%0d,%0d) want 1 (14,11)", erase_valid[2], erasex[2], erasey[2]); end
    tests_run++; if (headx[2] !== 5'd18 || tailx[2] !== 5'd15 || length[0] !== 8'd5) begin tests_failed++; $display("[TB] FAIL sat_ends: head=%0d tail=%0d len0=%0d want 18 15 5", headx[2], tailx[2], length[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dir = 2'b01; preyx = 5'd0; preyy = 5'd0; step_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    step_valid = 1'b0;
    tests_run++; if (busy[0] !== 1'b1 || step_ready[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL check_busy: busy=%b ready=%b want 1 0", busy[0], step_ready[0]); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    tests_run++; if (busy[0] !== 1'b1 || length[0] !== 8'd0 || step_done[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst: busy=%b len=%0d done=%b want 1 0 0", busy[0], length[0], step_done[0]); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (length[0] !== 8'd3 || headx[0] !== 5'd16 || step_ready[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_rst_init: len=%0d headx=%0d ready=%b want 3 16 1", length[0], headx[0], step_ready[0]); end
  endtask

  // Body kept as a queue of cells (y*32+x), head at the back; occupancy is a
  // search of that queue.
  task automatic test_random();
    int q[$];
    int cdir, req, d, hx, hy, nx, ny, px, py, old_tail, first;
    bit eat, grow, hitf;
    logic early;
    do_reset();
    q = {14 + 352, 15 + 352, 16 + 352};
    cdir = 1;
    for (int n = 0; n < 120; n++) begin
      req = int'($urandom_range(0, 3));
      d = (req == 3 - cdir) ? cdir : req;
      hx = q[$] % 32; hy = q[$] / 32;
      nx = hx; ny = hy;
      case (d)
        0: ny = (hy + 23) % 24;
        1: nx = (hx + 1) % 32;
        2: nx = (hx + 31) % 32;
        default: ny = (hy + 1) % 24;
      endcase
      if ($urandom_range(0, 2) == 0) begin px = nx; py = ny; end
      else begin px = int'($urandom_range(0, 31)); py = int'($urandom_range(0, 23)); end
      eat  = (px == nx) && (py == ny);
      grow = eat && (q.size() < 128);
      first = grow ? 0 : 1;
      hitf = 1'b0;
      for (int i = first; i < q.size(); i++) if (q[i] == ny * 32 + nx) hitf = 1'b1;
      do_step(req, px, py, early);
      tests_run++; if (early !== 1'b0 || step_done[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL rnd_done[%0d]: early=%b done=%b want 0 1", n, early, step_done[0]); end
      tests_run++; if (lose[0] !== hitf) begin tests_failed++; $display("[TB] FAIL rnd_lose[%0d]: got %b want %b", n, lose[0], hitf); end
      if (hitf) begin
        tests_run++; if (step_ready[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL rnd_dead_ready[%0d]: got %b want 0", n, step_ready[0]); end
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        q = {14 + 352, 15 + 352, 16 + 352};
        cdir = 1;
      end else begin
        old_tail = q[0];
        q.push_back(ny * 32 + nx);
        if (!grow) void'(q.pop_front());
        cdir = d;
        tests_run++; if (score[0] !== eat) begin tests_failed++; $display("[TB] FAIL rnd_score[%0d]: got %b want %b", n, score[0], eat); end
        tests_run++; if (headx[0] !== 5'(nx) || heady[0] !== 5'(ny)) begin tests_failed++; $display("[TB] FAIL rnd_head[%0d]: got (%0d,%0d) want (%0d,%0d)", n, headx[0], heady[0], nx, ny); end
        tests_run++; if (tailx[0] !== 5'(q[0] % 32) || taily[0] !== 5'(q[0] / 32)) begin tests_failed++; $display("[TB] FAIL rnd_tail[%0d]: got (%0d,%0d) want (%0d,%0d)", n, tailx[0], taily[0], q[0] % 32, q[0] / 32); end
        tests_run++; if (length[0] !== 8'(q.size())) begin tests_failed++; $display("[TB] FAIL rnd_length[%0d]: got %0d want %0d", n, length[0], q.size()); end
        tests_run++; if (erase_valid[0] !== !grow) begin tests_failed++; $display("[TB] FAIL rnd_erase_v[%0d]: got %b want %b", n, erase_valid[0], !grow); end
        if (!grow) begin
          tests_run++; if (erasex[0] !== 5'(old_tail % 32) || erasey[0] !== 5'(old_tail / 32)) begin tests_failed++; $display("[TB] FAIL rnd_erase[%0d]: got (%0d,%0d) want (%0d,%0d)", n, erasex[0], erasey[0], old_tail % 32, old_tail / 32); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_eat();
    test_wrap();
    test_reversal();
    test_self_collision();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
